adder_arbiter: RTL and testbench

//  Shares one 8-bit Parallel_Adder (add/sub, cin = subtract select) between two requesters.

---
 rtl/adder_arbiter.sv | 120 ++++++++++++
 tb/tb_adder_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one 8-bit add/sub adder between two requesters with a three-state sequencer

// Ripple-carry adder; overflow is carry into the MSB xor carry out of it
module parallel_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout,
   output logic       ovf
);
   logic [8:0] c;
   assign c[0] = cin;
   for (genvar g = 0; g < 8; g++) begin : g_bit
      assign sum[g]   = a[g] ^ b[g] ^ c[g];
      assign c[g+1]   = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
   end
   assign cout = c[8];
   assign ovf  = c[7] ^ c[8];
endmodule

module adder_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic       req0_sub,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic       req1_sub,
   output logic       resp0_valid,
   input  logic       resp0_ready,
   output logic [7:0] resp0_sum,
   output logic       resp0_cout,
   output logic       resp0_ovf,
   output logic       resp1_valid,
   input  logic       resp1_ready,
   output logic [7:0] resp1_sum,
   output logic       resp1_cout,
   output logic       resp1_ovf
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   state_t     state, state_nx;
   logic       last_grant, owner, op_sub, res_cout, res_ovf;
   logic [7:0] op_a, op_b, res_sum, add_sum;
   logic       add_cout, add_ovf, grant, any_valid, resp_fire;

   assign any_valid = req0_valid | req1_valid;
   assign grant     = (req0_valid && req1_valid) ? ((RR_EN != 0) ? ~last_grant : 1'b0) : req1_valid;
   assign resp_fire = (state == RESP) && (owner ? resp1_ready : resp0_ready);

   parallel_adder u_add (
      .a    (op_a),
      .b    (op_b ^ {8{op_sub}}),
      .cin  (op_sub),
      .sum  (add_sum),
      .cout (add_cout),
      .ovf  (add_ovf)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state, handshakes and owner-steered response outputs
   always_comb begin
      state_nx    = state;
      req0_ready  = rst_n && (state == IDLE) && req0_valid && !grant;
      req1_ready  = rst_n && (state == IDLE) && req1_valid && grant;
      resp0_valid = (state == RESP) && !owner;
      resp1_valid = (state == RESP) && owner;
      resp0_sum   = resp0_valid ? res_sum  : 8'h00;
      resp0_cout  = resp0_valid & res_cout;
      resp0_ovf   = resp0_valid & res_ovf;
      resp1_sum   = resp1_valid ? res_sum  : 8'h00;
      resp1_cout  = resp1_valid & res_cout;
      resp1_ovf   = resp1_valid & res_ovf;
      case (state)
         IDLE:    state_nx = any_valid ? CALC : IDLE;
         CALC:    state_nx = RESP;
         RESP:    state_nx = resp_fire ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture on accept, result capture after CALC, grant history on response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a       <= 8'h00;
         op_b       <= 8'h00;
         op_sub     <= 1'b0;
         owner      <= 1'b0;
         res_sum    <= 8'h00;
         res_cout   <= 1'b0;
         res_ovf    <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if (state == IDLE && any_valid) begin
            op_a   <= grant ? req1_a   : req0_a;
            op_b   <= grant ? req1_b   : req0_b;
            op_sub <= grant ? req1_sub : req0_sub;
            owner  <= grant;
         end
         if (state == CALC) begin
            res_sum  <= add_sum;
            res_cout <= add_cout;
            res_ovf  <= add_ovf;
         end
         if (resp_fire) last_grant <= owner;
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter, round-robin and fixed-priority instances
module tb_adder_arbiter;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       req0_valid = 0, req1_valid = 0, req0_sub = 0, req1_sub = 0;
   logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic       resp0_ready = 1, resp1_ready = 1;
   logic       req0_ready, req1_ready, resp0_valid, resp1_valid;
   logic [7:0] resp0_sum, resp1_sum;
   logic       resp0_cout, resp0_ovf, resp1_cout, resp1_ovf;
   logic       f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid;
   logic [7:0] f_resp0_sum, f_resp1_sum;
   logic       f_resp0_cout, f_resp0_ovf, f_resp1_cout, f_resp1_ovf;

   int          n_vec = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
   bit          rec = 0, prev_hold = 0;
   logic [10:0] q[$];
   logic        g_main[$], g_fix[$];
   logic [10:0] prev_out, last_rsp = '0, got_e, exp_e;

   always #5 clk = ~clk;

   adder_arbiter #(.RR_EN(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_sum(resp0_sum), .resp0_cout(resp0_cout), .resp0_ovf(resp0_ovf),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_sum(resp1_sum), .resp1_cout(resp1_cout), .resp1_ovf(resp1_ovf)
   );

   adder_arbiter #(.RR_EN(0)) dut_fix (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .resp0_valid(f_resp0_valid), .resp0_ready(resp0_ready), .resp0_sum(f_resp0_sum), .resp0_cout(f_resp0_cout), .resp0_ovf(f_resp0_ovf),
      .resp1_valid(f_resp1_valid), .resp1_ready(resp1_ready), .resp1_sum(f_resp1_sum), .resp1_cout(f_resp1_cout), .resp1_ovf(f_resp1_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {cout, ovf, sum}; overflow from operand/result signs, not from carries
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic [8:0] r;
      logic       v;
      r = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
      v = s ? ((a[7] != b[7]) && (r[7] != a[7])) : ((a[7] == b[7]) && (r[7] != a[7]));
      return {r[8], v, r[7:0]};
   endfunction

   // Scoreboard push on accept, pop/compare on response, stability and exclusivity checks
   always @(negedge clk) begin
      cyc++;
      if (req0_valid && req0_ready) begin
         q.push_back({1'b0, model(req0_a, req0_b, req0_sub)});
         acc_cyc = cyc;
         if (rec) g_main.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
         q.push_back({1'b1, model(req1_a, req1_b, req1_sub)});
         acc_cyc = cyc;
         if (rec) g_main.push_back(1'b1);
      end
      if (rec && req0_valid && f_req0_ready) g_fix.push_back(1'b0);
      if (rec && req1_valid && f_req1_ready) g_fix.push_back(1'b1);
      if (resp0_valid || resp1_valid) begin
         got_e = resp1_valid ? {1'b1, resp1_cout, resp1_ovf, resp1_sum} : {1'b0, resp0_cout, resp0_ovf, resp0_sum};
         check("one_owner", {31'd0, resp0_valid & resp1_valid}, 0);
         check("other_zero", resp1_valid ? {resp0_cout, resp0_ovf, resp0_sum} : {resp1_cout, resp1_ovf, resp1_sum}, 0);
         check("busy_ready", {req0_ready, req1_ready}, 0);
         if (prev_hold) check("stable", got_e, prev_out);
         else check("latency", cyc - acc_cyc, 2);
         if (resp1_valid ? resp1_ready : resp0_ready) begin
            if (q.size() == 0) check("unexpected_resp", q.size(), 1);
            else begin
               exp_e = q.pop_front();
               check("result", got_e, exp_e);
               last_rsp = got_e;
            end
            prev_hold = 0;
         end else begin
            prev_hold = 1;
            prev_out  = got_e;
         end
      end else prev_hold = 0;
   end

   task automatic drain();
      for (int i = 0; i < 30 && q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("drain", q.size(), 0);
   endtask

   task automatic wait_hs(input bit n);
      bit hs = 0;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         hs = n ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
      end
      check("accept", {31'd0, hs}, 1);
   endtask

   task automatic op(input bit n, input logic [7:0] a, input logic [7:0] b, input logic s, input logic [9:0] kat);
      @(posedge clk); #1;
      if (n) begin req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1; end
      else   begin req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1; end
      wait_hs(n);
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 0;
      drain();
      check("kat", last_rsp, {n, kat});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] ra, rb;
      logic       rs, rn;
      req0_valid = 1;
      req1_valid = 1;
      @(negedge clk);
      check("rst_ready", {req0_ready, req1_ready}, 0);
      check("rst_resp", {resp0_valid, resp0_cout, resp0_ovf, resp0_sum, resp1_valid, resp1_cout, resp1_ovf, resp1_sum}, 0);
      req0_valid = 0;
      req1_valid = 0;
      @(posedge clk); #1 rst_n = 1;

      op(0, 8'h05, 8'h03, 0, {1'b0, 1'b0, 8'h08});
      op(1, 8'h03, 8'h05, 1, {1'b0, 1'b0, 8'hFE});
      op(1, 8'h80, 8'h01, 1, {1'b1, 1'b1, 8'h7F});
      op(0, 8'h7F, 8'h01, 0, {1'b0, 1'b1, 8'h80});
      op(1, 8'hFF, 8'h01, 0, {1'b1, 1'b0, 8'h00});
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rn = 1'($urandom);
         op(rn, ra, rb, rs, model(ra, rb, rs));
      end
      op(1, 8'h10, 8'h20, 0, {1'b0, 1'b0, 8'h30});

      @(posedge clk); #1;
      req0_a = 8'h11; req0_b = 8'h22; req0_sub = 0;
      req1_a = 8'h40; req1_b = 8'h30; req1_sub = 1;
      g_main.delete(); g_fix.delete();
      rec = 1; req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 80 && (g_main.size() < 4 || g_fix.size() < 4); i++) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk); #1;
      rec = 0; req0_valid = 0; req1_valid = 0;
      drain();
      repeat (5) @(posedge clk);
      check("rr_count", {31'd0, g_main.size() >= 4}, 1);
      check("fix_count", {31'd0, g_fix.size() >= 4}, 1);
      for (int i = 0; i < 4; i++) begin
         if (g_main.size() > i) check($sformatf("rr_grant%0d", i), {31'd0, g_main[i]}, i % 2);
         if (g_fix.size() > i) check($sformatf("fix_grant%0d", i), {31'd0, g_fix[i]}, 0);
      end

      @(posedge clk); #1;
      resp0_ready = 0;
      req0_a = 8'h33; req0_b = 8'h11; req0_sub = 0; req0_valid = 1;
      wait_hs(0);
      @(posedge clk); #1;
      req0_valid = 0;
      req1_a = 8'h01; req1_b = 8'h01; req1_sub = 0; req1_valid = 1;
      for (int i = 0; i < 10 && !resp0_valid; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("hold_valid", {31'd0, resp0_valid}, 1);
      check("hold_no_accept", q.size(), 1);
      @(posedge clk); #1;
      resp0_ready = 1;
      req1_valid = 0;
      drain();
      check("hold_kat", last_rsp, {1'b0, 1'b0, 1'b0, 8'h44});

      @(posedge clk); #1;
      req0_a = 8'h09; req0_b = 8'h09; req0_sub = 0; req0_valid = 1;
      wait_hs(0);
      @(posedge clk); #1;
      rst_n = 0;
      q.delete();
      req1_valid = 1;
      #1;
      check("async_rst_resp", {resp0_valid, resp0_cout, resp0_ovf, resp0_sum, resp1_valid, resp1_cout, resp1_ovf, resp1_sum}, 0);
      check("async_rst_ready", {req0_ready, req1_ready}, 0);
      repeat (2) @(negedge clk);
      check("rst_hold_resp", {30'd0, resp0_valid, resp1_valid}, 0);
      @(posedge clk); #1;
      g_main.delete();
      rec = 1;
      rst_n = 1;
      for (int i = 0; i < 10 && g_main.size() == 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("post_rst_seen", g_main.size(), 1);
      if (g_main.size() > 0) check("post_rst_grant", {31'd0, g_main[0]}, 0);
      @(posedge clk); #1;
      rec = 0; req0_valid = 0; req1_valid = 0;
      drain();
      repeat (5) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
